// File: rtl/alu_pkg.sv
// Shared definitions for the execution stage: opcodes, widths and FSM states.
package alu_pkg;

  localparam int DATA_W     = 4;
  localparam int REG_ADDR_W = 3;
  localparam int REG_CNT    = 8;

  localparam logic [2:0] OP_ADD  = 3'b000;
  localparam logic [2:0] OP_SUB  = 3'b001;
  localparam logic [2:0] OP_AND  = 3'b010;
  localparam logic [2:0] OP_OR   = 3'b011;
  localparam logic [2:0] OP_XOR  = 3'b100;
  localparam logic [2:0] OP_NAND = 3'b101;
  localparam logic [2:0] OP_NOR  = 3'b110;
  localparam logic [2:0] OP_SLT  = 3'b111;

  typedef enum logic {S_IDLE, S_EXEC} state_t;

endpackage

// File: rtl/ALU.sv
// Purely combinational 4-bit ALU with a zero flag; arithmetic wraps modulo 16.
module ALU (
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic [2:0] op,
  output logic [3:0] result,
  output logic       zero
);
  import alu_pkg::*;

  always_comb begin
    result = '0;
    case (op)
      OP_ADD:  result = a + b;
      OP_SUB:  result = a - b;
      OP_AND:  result = a & b;
      OP_OR:   result = a | b;
      OP_XOR:  result = a ^ b;
      OP_NAND: result = ~(a & b);
      OP_NOR:  result = ~(a | b);
      OP_SLT:  result = {3'b000, (a < b)};
      default: result = '0;
    endcase
  end

  assign zero = (result == 4'd0);

endmodule

// File: rtl/alu_regfile.sv
// Register file: one synchronous write port, three asynchronous read ports.
module alu_regfile #(
  parameter int REG_CNT = 8,
  parameter int DATA_W  = 4,
  parameter int ADDR_W  = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [ADDR_W-1:0] raddr1,
  input  logic [ADDR_W-1:0] raddr2,
  input  logic [ADDR_W-1:0] raddr3,
  output logic [DATA_W-1:0] rdata1,
  output logic [DATA_W-1:0] rdata2,
  output logic [DATA_W-1:0] rdata3
);

  logic [DATA_W-1:0] mem [REG_CNT];

  // Each register has its own reset so the whole file clears asynchronously.
  generate
    for (genvar gi = 0; gi < REG_CNT; gi++) begin : g_reg
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          mem[gi] <= '0;
        end else if (we && (waddr == ADDR_W'(gi))) begin
          mem[gi] <= wdata;
        end
      end
    end
  endgenerate

  assign rdata1 = mem[raddr1];
  assign rdata2 = mem[raddr2];
  assign rdata3 = mem[raddr3];

endmodule

// File: rtl/alu_exec_unit.sv
// Two-state execution stage: latch operands on accept, run the ALU, write back
// the result on the following edge and pulse done.
module alu_exec_unit #(
  parameter int REG_CNT = 8,
  parameter int DATA_W  = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              instr_valid,
  output logic              instr_ready,
  input  logic [2:0]        instr_op,
  input  logic [2:0]        instr_rd,
  input  logic [2:0]        instr_rs1,
  input  logic [2:0]        instr_rs2,
  input  logic              ld_en,
  input  logic [2:0]        ld_addr,
  input  logic [DATA_W-1:0] ld_data,
  input  logic [2:0]        dbg_addr,
  output logic [DATA_W-1:0] dbg_data,
  output logic              done,
  output logic [DATA_W-1:0] res_data,
  output logic              res_zero,
  output logic              busy
);
  import alu_pkg::*;

  state_t                  state;
  logic [2:0]              op_reg;
  logic [REG_ADDR_W-1:0]   rd_reg;
  logic [DATA_W-1:0]       a_reg;
  logic [DATA_W-1:0]       b_reg;
  logic [DATA_W-1:0]       rs1_data;
  logic [DATA_W-1:0]       rs2_data;
  logic [DATA_W-1:0]       alu_result;
  logic                    alu_zero;
  logic                    rf_we;
  logic [REG_ADDR_W-1:0]   rf_waddr;
  logic [DATA_W-1:0]       rf_wdata;
  logic                    in_exec;

  assign in_exec     = (state == S_EXEC);
  assign instr_ready = (state == S_IDLE);
  assign busy        = in_exec;

  // Writeback owns the port in EXEC, external loads own it in IDLE.
  assign rf_we    = in_exec | ld_en;
  assign rf_waddr = in_exec ? rd_reg     : ld_addr;
  assign rf_wdata = in_exec ? alu_result : ld_data;

  alu_regfile #(
    .REG_CNT (REG_CNT),
    .DATA_W  (DATA_W),
    .ADDR_W  (REG_ADDR_W)
  ) u_regfile (
    .clk    (clk),
    .rst    (rst),
    .we     (rf_we),
    .waddr  (rf_waddr),
    .wdata  (rf_wdata),
    .raddr1 (instr_rs1),
    .raddr2 (instr_rs2),
    .raddr3 (dbg_addr),
    .rdata1 (rs1_data),
    .rdata2 (rs2_data),
    .rdata3 (dbg_data)
  );

  ALU u_alu (
    .a      (a_reg),
    .b      (b_reg),
    .op     (op_reg),
    .result (alu_result),
    .zero   (alu_zero)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= S_IDLE;
      op_reg   <= '0;
      rd_reg   <= '0;
      a_reg    <= '0;
      b_reg    <= '0;
      done     <= 1'b0;
      res_data <= '0;
      res_zero <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        S_IDLE: begin
          if (instr_valid) begin
            // Operands are the pre-edge register values, even if a load lands now.
            op_reg <= instr_op;
            rd_reg <= instr_rd;
            a_reg  <= rs1_data;
            b_reg  <= rs2_data;
            state  <= S_EXEC;
          end
        end
        S_EXEC: begin
          res_data <= alu_result;
          res_zero <= alu_zero;
          done     <= 1'b1;
          state    <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_exec_unit.sv
// Directed bench for alu_exec_unit: cycle-by-cycle model compare plus literal checks.
module tb_alu_exec_unit;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       instr_valid = 1'b0;
  logic       instr_ready;
  logic [2:0] instr_op = '0;
  logic [2:0] instr_rd = '0;
  logic [2:0] instr_rs1 = '0;
  logic [2:0] instr_rs2 = '0;
  logic       ld_en = 1'b0;
  logic [2:0] ld_addr = '0;
  logic [3:0] ld_data = '0;
  logic [2:0] dbg_addr = '0;
  logic [3:0] dbg_data;
  logic       done;
  logic [3:0] res_data;
  logic       res_zero;
  logic       busy;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  alu_exec_unit dut (
    .clk         (clk),
    .rst         (rst),
    .instr_valid (instr_valid),
    .instr_ready (instr_ready),
    .instr_op    (instr_op),
    .instr_rd    (instr_rd),
    .instr_rs1   (instr_rs1),
    .instr_rs2   (instr_rs2),
    .ld_en       (ld_en),
    .ld_addr     (ld_addr),
    .ld_data     (ld_data),
    .dbg_addr    (dbg_addr),
    .dbg_data    (dbg_data),
    .done        (done),
    .res_data    (res_data),
    .res_zero    (res_zero),
    .busy        (busy)
  );

  // ---------------- behavioural model ----------------
  function automatic int alu_model(input int op, input int a, input int b);
    case (op)
      0: return (a + b) % 16;
      1: return (a - b + 16) % 16;
      2: return a & b;
      3: return a | b;
      4: return a ^ b;
      5: return 15 - (a & b);
      6: return 15 - (a | b);
      default: return (a < b) ? 1 : 0;
    endcase
  endfunction

  int m_regs [8];
  bit m_pend;
  int m_op, m_rd, m_a, m_b;
  bit m_done;
  int m_res;
  bit m_zero;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 8; i++) m_regs[i] <= 0;
      m_pend <= 0; m_done <= 0; m_res <= 0; m_zero <= 0;
      m_op <= 0; m_rd <= 0; m_a <= 0; m_b <= 0;
    end else begin
      m_done <= 0;
      if (m_pend) begin
        m_regs[m_rd] <= alu_model(m_op, m_a, m_b);
        m_res        <= alu_model(m_op, m_a, m_b);
        m_zero       <= (alu_model(m_op, m_a, m_b) == 0);
        m_done       <= 1;
        m_pend       <= 0;
      end else begin
        if (instr_valid) begin
          m_pend <= 1;
          m_op   <= int'(instr_op);
          m_rd   <= int'(instr_rd);
          m_a    <= m_regs[instr_rs1];
          m_b    <= m_regs[instr_rs2];
        end
        if (ld_en) m_regs[ld_addr] <= int'(ld_data);
      end
    end
  end

  task automatic chk(input string name, input int got, input int exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got=%0d expected=%0d at t=%0t", name, got, exp, $time);
    end
  endtask

  // Every-cycle compare against the model.
  always @(posedge clk) begin
    #2;
    chk("m_ready", int'(instr_ready), int'(!m_pend));
    chk("m_busy",  int'(busy),        int'(m_pend));
    chk("m_done",  int'(done),        int'(m_done));
    chk("m_res",   int'(res_data),    m_res);
    chk("m_zero",  int'(res_zero),    int'(m_zero));
    chk("m_dbg",   int'(dbg_data),    m_regs[dbg_addr]);
  end

  // ---------------- stimulus helpers ----------------
  task automatic load(input int addr, input int data);
    @(negedge clk);
    ld_en = 1; ld_addr = 3'(addr); ld_data = 4'(data);
    @(posedge clk); #1;
    ld_en = 0;
  endtask

  task automatic run_instr(input int op, input int rd, input int rs1, input int rs2,
                           output int res, output int zero, output int lat);
    int waits;
    waits = 0;
    @(negedge clk);
    while (!instr_ready && waits < 4) begin
      @(negedge clk);
      waits++;
    end
    if (!instr_ready) chk("ready_timeout", int'(instr_ready), 1);
    instr_valid = 1; instr_op = 3'(op); instr_rd = 3'(rd);
    instr_rs1 = 3'(rs1); instr_rs2 = 3'(rs2);
    @(posedge clk); #1;
    instr_valid = 0;
    lat = 0;
    do begin
      @(posedge clk); #2;
      lat++;
    end while (!done && lat < 4);
    res = int'(res_data);
    zero = int'(res_zero);
    $display("instr op=%0d rd=%0d rs1=%0d rs2=%0d -> res=%0h zero=%0d lat=%0d",
             op, rd, rs1, rs2, res, zero, lat);
  endtask

  task automatic peek(input int addr, input int exp, input string name);
    dbg_addr = 3'(addr);
    #1;
    chk(name, int'(dbg_data), exp);
  endtask

  // ---------------- directed tests ----------------
  int r, z, l;
  bit [3:0] pat;
  int alu_exp [8] = '{4'h0, 4'h4, 4'h2, 4'hE, 4'hC, 4'hD, 4'h1, 4'h0};

  initial begin
    #1 rst = 1;
    #2;
    chk("rst_ready", int'(instr_ready), 1);
    chk("rst_busy",  int'(busy), 0);
    chk("rst_done",  int'(done), 0);
    chk("rst_res",   int'(res_data), 0);
    @(negedge clk); @(negedge clk);
    rst = 0;

    // basic ADD
    load(1, 5); load(2, 3);
    run_instr(0, 3, 1, 2, r, z, l);
    chk("add_lat", l, 1); chk("add_res", r, 8); chk("add_zero", z, 0);
    peek(3, 8, "add_dbg");

    // wrap and zero
    load(1, 9);
    run_instr(0, 4, 1, 1, r, z, l);
    chk("wrap_res", r, 2);
    run_instr(1, 5, 1, 1, r, z, l);
    chk("sub_res", r, 0); chk("sub_zero", z, 1);

    // SLT both ways
    load(1, 2); load(2, 7);
    run_instr(7, 6, 1, 2, r, z, l);
    chk("slt_lt", r, 1);
    run_instr(7, 6, 2, 1, r, z, l);
    chk("slt_ge", r, 0); chk("slt_zero", z, 1);

    // all opcodes on A=A, B=6
    load(1, 10); load(2, 6);
    for (int op = 0; op < 8; op++) begin
      run_instr(op, 0, 1, 2, r, z, l);
      chk($sformatf("op%0d_res", op), r, alu_exp[op]);
    end

    // back-to-back with instr_valid held high
    load(1, 5); load(2, 3);
    @(negedge clk);
    instr_valid = 1; instr_op = 0; instr_rd = 3; instr_rs1 = 1; instr_rs2 = 2;
    pat[3] = instr_ready;
    @(posedge clk); #2; pat[2] = instr_ready;
    @(negedge clk);
    instr_rd = 3; instr_rs1 = 3; instr_rs2 = 1;
    @(posedge clk); #2; pat[1] = instr_ready;
    chk("b2b_done1", int'(done), 1); chk("b2b_res1", int'(res_data), 8);
    @(posedge clk); #2; pat[0] = instr_ready;
    @(negedge clk); instr_valid = 0;
    @(posedge clk); #2;
    chk("b2b_done2", int'(done), 1); chk("b2b_res2", int'(res_data), 13);
    chk("b2b_ready_pat", int'(pat), 4'b1010);
    $display("b2b ready pattern=%b res=%0d", pat, res_data);

    // load during EXEC is ignored
    @(negedge clk);
    instr_valid = 1; instr_op = 0; instr_rd = 0; instr_rs1 = 1; instr_rs2 = 2;
    @(posedge clk); #1;
    instr_valid = 0; ld_en = 1; ld_addr = 2; ld_data = 4'hF;
    @(posedge clk); #1;
    ld_en = 0; #1;
    chk("exec_ld_res", int'(res_data), 8);
    peek(2, 3, "exec_ld_ignored");
    $display("load during exec: r2=%0d", dbg_data);

    // load on the accept edge: operands see old r1
    @(negedge clk);
    instr_valid = 1; instr_op = 0; instr_rd = 7; instr_rs1 = 1; instr_rs2 = 1;
    ld_en = 1; ld_addr = 1; ld_data = 6;
    @(posedge clk); #1;
    instr_valid = 0; ld_en = 0;
    @(posedge clk); #2;
    chk("same_edge_done", int'(done), 1);
    chk("same_edge_res", int'(res_data), 10);
    peek(1, 6, "same_edge_r1");
    $display("same-edge load: res=%0d r1=%0d", res_data, dbg_data);

    // reset during EXEC
    @(negedge clk);
    instr_valid = 1; instr_op = 0; instr_rd = 3; instr_rs1 = 1; instr_rs2 = 2;
    @(posedge clk); #1;
    instr_valid = 0;
    chk("pre_rst_busy", int'(busy), 1);
    rst = 1;
    @(negedge clk); rst = 0;
    @(posedge clk); #2;
    chk("post_rst_done", int'(done), 0);
    chk("post_rst_ready", int'(instr_ready), 1);
    chk("post_rst_res", int'(res_data), 0);
    peek(3, 0, "post_rst_r3");
    $display("reset mid-exec: ready=%0d done=%0d r3=%0d", instr_ready, done, dbg_data);

    repeat (2) @(posedge clk);
    #3;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
